pulse_train: RTL
================

PULSE_TRAIN -- requirements
Module: pulse_train

Interface
REQ-001 SHALL have parameter CNT, default 3: number of high pulses per train; legal range 1..255.
REQ-002 SHALL have parameter HI, default 2: cycles high per pulse; legal range 1..1024.
REQ-003 SHALL have parameter LO, default 2: cycles low between pulses; legal range 1..1024.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port trig, input, 1 bit: level trigger, typically fed by the delayed-pulse generator; only its rising edge is used.
REQ-007 SHALL have port pulse, output, 1 bit: the registered train output.
REQ-008 SHALL have port busy, output, 1 bit: high while a train is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle strobe when a train completes.

Function
REQ-010 SHALL register trig into trig_q each cycle; a rising edge is trig=1 and trig_q=0 at a clock edge.
REQ-011 SHALL implement the FSM states IDLE, HIGH and LOW.
REQ-012 SHALL, in IDLE on a rising edge, go to HIGH, set pulse=1 and busy=1 at that edge, load the phase counter and clear the pulse counter.
REQ-013 SHALL hold HIGH for exactly HI cycles; after HI cycles, if pulses emitted < CNT go to LOW with pulse=0, otherwise go to IDLE.
REQ-014 SHALL hold LOW for exactly LO cycles with pulse=0, then go to HIGH with pulse=1.
REQ-015 SHALL, on the HIGH-to-IDLE transition, assert done for exactly one cycle (the first IDLE cycle) and deassert busy in that same cycle.
REQ-016 SHALL keep busy high for exactly CNT*HI + (CNT-1)*LO cycles per train.
REQ-017 SHALL produce pulse, busy and done purely from registers, with no combinational path from trig.
REQ-018 SHALL honour a rising edge that arrives in the done cycle (state IDLE): a new train starts and done still pulses for one cycle.
REQ-019 SHALL ignore trig rising edges while busy=1 unless PULSE_TRAIN_RETRIG_EN is defined.
REQ-020 SHALL size the phase counter to ceil(log2(max(HI,LO)+1)) bits and the pulse counter to ceil(log2(CNT+1)) bits; neither counter may wrap within a train.
REQ-021 SHALL NOT start a train when trig is held high continuously; exactly one train per rising edge.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, set state=IDLE, pulse=0, busy=0, done=0, trig_q=0 and both counters to 0.
REQ-023 SHALL, on reset mid-train, abort the train with no done strobe.
REQ-024 SHALL treat trig=1 at the first edge after rst deasserts as a rising edge.

Configuration
REQ-025 SHALL, when PULSE_TRAIN_RETRIG_EN is defined, restart the train on a rising edge while busy=1: state=HIGH, counters reloaded, pulse=1 and no done strobe for the aborted train.
REQ-026 SHALL, without PULSE_TRAIN_RETRIG_EN, ignore such edges and leave no retrigger logic in the design.

Structure
REQ-027 SHALL take the FSM state type (IDLE/HIGH/LOW) and the log2 sizing function from the shared package pulse_pkg.
REQ-028 SHALL implement edge detection (trig_q register plus rise output) as sub-module pulse_edge, reused by other pulse blocks.

Verification
REQ-029 SHALL cover: CNT=3, HI=2, LO=2, single trig rise -> pulse pattern 1100110011, busy high 10 cycles, done at cycle 11.
REQ-030 SHALL cover: CNT=1, HI=1, LO=1 -> pulse high for 1 cycle, busy 1 cycle, done in the next cycle.
REQ-031 SHALL cover: trig held high 50 cycles -> exactly one train and one done.
REQ-032 SHALL cover: second rise at cycle 4 of a default train -> ignored without the macro; with the macro, pulse restarts and 10 more busy cycles follow with a single done.
REQ-033 SHALL cover: rise coincident with done -> back-to-back trains, busy low for exactly 1 cycle.
REQ-034 SHALL cover: rst=1 at cycle 5 of a train -> all outputs 0 next cycle and no done.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse-generator family.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // Bits needed to hold max_val, i.e. ceil(log2(max_val+1)); never below 1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    for (int i = 0; i < 32; i++) begin
      if ((max_val >> i) != 0) w = unsigned'(i) + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pulse_edge.sv
// Rising-edge detector: registers trig and flags trig=1 while last sample was 0.
module pulse_edge (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic rise
);

  logic trig_d;
  logic trig_q;

  always_comb trig_d = trig;

  // NOTE: flops always use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_d;
  end

  assign rise = trig & ~trig_q;

endmodule

// File: rtl/pulse_train.sv
// Emits CNT pulses of HI cycles separated by LO cycles on each rising edge of trig.
// Define PULSE_TRAIN_RETRIG_EN to let a rising edge restart a train in progress.
module pulse_train
  import pulse_pkg::*;
#(
  parameter int unsigned CNT = 3,
  parameter int unsigned HI  = 2,
  parameter int unsigned LO  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic pulse,
  output logic busy,
  output logic done
);

  localparam int unsigned PH_MAX = (HI > LO) ? HI : LO;
  localparam int unsigned PH_W   = cnt_width(PH_MAX);
  localparam int unsigned PC_W   = cnt_width(CNT);

  localparam logic [PH_W-1:0] HI_LD = PH_W'(HI);
  localparam logic [PH_W-1:0] LO_LD = PH_W'(LO);

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [PC_W-1:0] pcnt_q,  pcnt_d;
  logic            pulse_q, pulse_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            rise;
  logic            last_phase;
  logic            last_pulse;

  pulse_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .rise (rise)
  );

  // phase counts down the cycles left in HIGH/LOW; pcnt counts completed pulses.
  assign last_phase = (phase_q == PH_W'(1));
  assign last_pulse = ((32'(pcnt_q) + 32'd1) >= CNT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          phase_d = HI_LD;
          pcnt_d  = '0;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_HIGH: begin
        if (!last_phase) begin
          phase_d = phase_q - PH_W'(1);
        end else if (!last_pulse) begin
          state_d = ST_LOW;
          phase_d = LO_LD;
          pcnt_d  = pcnt_q + PC_W'(1);
          pulse_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          phase_d = '0;
          pcnt_d  = '0;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_LOW: begin
        if (!last_phase) begin
          phase_d = phase_q - PH_W'(1);
        end else begin
          state_d = ST_HIGH;
          phase_d = HI_LD;
          pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        pcnt_d  = '0;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

`ifdef PULSE_TRAIN_RETRIG_EN
    // A restart overrides whatever the running train would have done, including its done strobe.
    if (rise && (state_q != ST_IDLE)) begin
      state_d = ST_HIGH;
      phase_d = HI_LD;
      pcnt_d  = '0;
      pulse_d = 1'b1;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
